// File: rtl/crypto_frame_builder.sv
// AXI-Stream front end for crypto_module: emits key beat, header beat, then
// passes the payload through unchanged, maintaining the 64-bit IV invocation counter.
module crypto_frame_builder #(
    parameter int          DATA_WIDTH = 128,
    parameter logic [31:0] CTR_INIT   = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          key_in,
    input  logic [31:0]           iv_fixed,
    input  logic                  iv_load,
    input  logic [63:0]           iv_load_val,
    output logic                  S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  iv_exhausted,
    output logic                  busy,
    output logic [31:0]           frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY,
        ST_HDR,
        ST_PAYLOAD
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  key_snap_q, key_snap_d;
    logic [31:0]   ivf_snap_q, ivf_snap_d;
    logic [63:0]   inv_snap_q, inv_snap_d;
    logic [63:0]   inv_ctr_q, inv_ctr_d;
    logic          exhausted_q, exhausted_d;
    logic [31:0]   frame_count_q, frame_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            key_snap_q    <= '0;
            ivf_snap_q    <= '0;
            inv_snap_q    <= '0;
            inv_ctr_q     <= '0;
            exhausted_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            key_snap_q    <= key_snap_d;
            ivf_snap_q    <= ivf_snap_d;
            inv_snap_q    <= inv_snap_d;
            inv_ctr_q     <= inv_ctr_d;
            exhausted_q   <= exhausted_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        key_snap_d    = key_snap_q;
        ivf_snap_d    = ivf_snap_q;
        inv_snap_d    = inv_snap_q;
        inv_ctr_d     = inv_ctr_q;
        exhausted_d   = exhausted_q;
        frame_count_d = frame_count_q;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A counter load takes priority; any pending frame start waits a cycle
                // so that it picks up the freshly loaded counter.
                if (iv_load) begin
                    inv_ctr_d   = iv_load_val;
                    exhausted_d = 1'b0;
                end else if (S_AXIS_TVALID && !exhausted_q) begin
                    key_snap_d = key_in;
                    ivf_snap_d = iv_fixed;
                    inv_snap_d = inv_ctr_q;
                    state_d    = ST_KEY;
                end
            end
            ST_KEY: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = key_snap_q;
                if (M_AXIS_TREADY) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = {ivf_snap_q, inv_snap_q, CTR_INIT};
                if (M_AXIS_TREADY) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                M_AXIS_TVALID = S_AXIS_TVALID;
                M_AXIS_TDATA  = S_AXIS_TDATA;
                M_AXIS_TLAST  = S_AXIS_TLAST;
                S_AXIS_TREADY = M_AXIS_TREADY;
                if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) begin
                    state_d       = ST_IDLE;
                    frame_count_d = frame_count_q + 32'd1;
                    // The all-ones value is the last usable nonce: hold it and block.
                    if (inv_ctr_q == 64'hFFFF_FFFF_FFFF_FFFF) begin
                        exhausted_d = 1'b1;
                    end else begin
                        inv_ctr_d = inv_ctr_q + 64'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign iv_exhausted = exhausted_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_crypto_frame_builder.sv
// Directed + randomized bench for crypto_frame_builder with a queue-based
// reference model of the emitted beat sequence and the invocation counter.
module tb_crypto_frame_builder;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic [31:0]  iv_fixed;
    logic         iv_load;
    logic [63:0]  iv_load_val;
    logic         S_AXIS_TREADY;
    logic [127:0] S_AXIS_TDATA;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TVALID;
    logic         M_AXIS_TVALID;
    logic [127:0] M_AXIS_TDATA;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic         iv_exhausted;
    logic         busy;
    logic [31:0]  frame_count;

    crypto_frame_builder dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .iv_fixed      (iv_fixed),
        .iv_load       (iv_load),
        .iv_load_val   (iv_load_val),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .iv_exhausted  (iv_exhausted),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [63:0]  m_ctr;
    logic [31:0]  m_fc;
    logic         m_exh;
    logic [127:0] pay[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_iv_load(input logic [63:0] val);
        iv_load     = 1'b1;
        iv_load_val = val;
        @(posedge clk); #1;
        iv_load     = 1'b0;
        m_ctr       = val;
        m_exh       = 1'b0;
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    // mode: 0 = ready high, 1 = ready toggles every cycle, 2 = random ready
    task automatic send_frame(input logic [127:0] key, input logic [31:0] ivf, input int mode,
                              input bit midload, input int abort_after);
        logic [127:0] exp_q[$];
        int total, pi, budget, consumed;
        bit s_xfer, ml_done;
        exp_q.push_back(key);
        exp_q.push_back({ivf, m_ctr, 32'h0000_0001});
        foreach (pay[i]) exp_q.push_back(pay[i]);
        total = exp_q.size();
        pi = 0; budget = 0; ml_done = 0;
        key_in        = key;
        iv_fixed      = ivf;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = pay[0];
        S_AXIS_TLAST  = (pay.size() == 1);
        M_AXIS_TREADY = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (exp_q.size() > 0 && budget < 2000) begin
            @(negedge clk);
            consumed = total - exp_q.size();
            chk("s_tready", {127'd0, S_AXIS_TREADY}, {127'd0, (consumed >= 2) ? M_AXIS_TREADY : 1'b0});
            if (M_AXIS_TVALID) begin
                chk("m_tdata", M_AXIS_TDATA, exp_q[0]);
                chk("m_tlast", {127'd0, M_AXIS_TLAST}, {127'd0, exp_q.size() == 1});
                if (M_AXIS_TREADY) void'(exp_q.pop_front());
            end
            s_xfer = S_AXIS_TVALID && S_AXIS_TREADY;
            @(posedge clk); #1;
            iv_load = 1'b0;
            if (s_xfer) begin
                pi++;
                if (pi >= pay.size()) begin
                    S_AXIS_TVALID = 1'b0;
                    S_AXIS_TLAST  = 1'b0;
                end else begin
                    S_AXIS_TDATA = pay[pi];
                    S_AXIS_TLAST = (pi == pay.size() - 1);
                end
            end
            if (midload && !ml_done && (total - exp_q.size()) >= 2 && S_AXIS_TVALID) begin
                iv_load     = 1'b1;
                iv_load_val = 64'd5;
                ml_done     = 1'b1;
            end
            if (abort_after > 0 && pi == abort_after) begin
                rst = 1'b1;
                #1;
                chk("rst_m_tvalid", {127'd0, M_AXIS_TVALID}, 128'd0);
                chk("rst_busy", {127'd0, busy}, 128'd0);
                chk("rst_frame_count", {96'd0, frame_count}, 128'd0);
                chk("rst_s_tready", {127'd0, S_AXIS_TREADY}, 128'd0);
                m_ctr = '0; m_fc = '0; m_exh = 1'b0;
                S_AXIS_TVALID = 1'b0;
                S_AXIS_TLAST  = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (mode == 1) M_AXIS_TREADY = ~M_AXIS_TREADY;
            else if (mode == 2) M_AXIS_TREADY = 1'($urandom_range(0, 1));
            else M_AXIS_TREADY = 1'b1;
            budget++;
        end
        iv_load = 1'b0;
        chk("frame_timeout", 128'(exp_q.size()), 128'd0);
        m_fc++;
        if (m_ctr == 64'hFFFF_FFFF_FFFF_FFFF) m_exh = 1'b1;
        else m_ctr = m_ctr + 64'd1;
        chk("frame_count", {96'd0, frame_count}, {96'd0, m_fc});
        chk("iv_exhausted", {127'd0, iv_exhausted}, {127'd0, m_exh});
        chk("busy_after", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        key_in = '0; iv_fixed = '0; iv_load = 1'b0; iv_load_val = '0;
        S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b1;
        m_ctr = '0; m_fc = '0; m_exh = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_tvalid", {127'd0, M_AXIS_TVALID}, 128'd0);
        chk("reset_m_tdata", M_AXIS_TDATA, 128'd0);
        chk("reset_m_tlast", {127'd0, M_AXIS_TLAST}, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_exh", {127'd0, iv_exhausted}, 128'd0);
        chk("reset_frame_count", {96'd0, frame_count}, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single known frame, then a back-to-back frame with a new key
        do_iv_load(64'hf2cb949b8fb0013e);
        pay.delete();
        pay.push_back(128'h4df64bff1fa11895af337eb66b66e129);
        pay.push_back(128'h1fda3cf888);
        send_frame(128'hee84e19cda87a76291eaaf2054aef812, 32'h13360015, 0, 0, 0);
        fill_random(4);
        send_frame(128'ha3557da8c75e9dfde2ff0bd90d0156f8, 32'h13360015, 0, 0, 0);

        // Backpressure patterns
        fill_random(5);
        send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom, 1, 0, 0);
        fill_random(6);
        send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom, 2, 0, 0);

        // iv_load mid-frame must be ignored
        fill_random(3);
        send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom, 2, 1, 0);
        fill_random(1);
        send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom, 0, 0, 0);

        // Exhaustion and recovery
        do_iv_load(64'hFFFF_FFFF_FFFF_FFFF);
        fill_random(2);
        send_frame({$urandom, $urandom, $urandom, $urandom}, 32'hcafef00d, 0, 0, 0);
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 128'h1234;
        S_AXIS_TLAST  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_s_tready", {127'd0, S_AXIS_TREADY}, 128'd0);
            chk("stall_m_tvalid", {127'd0, M_AXIS_TVALID}, 128'd0);
        end
        chk("stall_busy", {127'd0, busy}, 128'd0);
        @(posedge clk); #1;
        do_iv_load(64'd0);
        chk("load_defers_start", {127'd0, busy}, 128'd0);
        chk("load_clears_exh", {127'd0, iv_exhausted}, 128'd0);
        fill_random(1);
        send_frame({$urandom, $urandom, $urandom, $urandom}, 32'h0badbeef, 0, 0, 0);

        // Reset in the middle of the payload, then a clean frame
        fill_random(4);
        send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom, 0, 0, 2);
        fill_random(2);
        send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom, 0, 0, 0);

        // A few more random frames
        for (int f = 0; f < 4; f++) begin
            fill_random(int'($urandom_range(1, 6)));
            send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom,
                       int'($urandom_range(0, 2)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
